// File: rtl/ps2_pkg.sv
// PS/2 receiver shared types: frame FSM encoding,
// prefix byte values and frame geometry.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } ps2_state_e;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;
   localparam int unsigned PS2_NBITS = 8;

   function automatic logic odd_ok(input logic [7:0] b, input logic p);
      return ^{b, p};
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 lines plus a history
// flop on the clock line producing a falling-edge strobe.
module ps2_sync_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic ps2_clk_i,
   input  logic ps2_dat_i,
   output logic fall_o,
   output logic dat_o
);

   logic [1:0] clk_s_q;
   logic [1:0] dat_s_q;
   logic       clk_h_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         clk_s_q <= 2'b11;
         dat_s_q <= 2'b11;
         clk_h_q <= 1'b1;
      end else begin
         clk_s_q <= {clk_s_q[0], ps2_clk_i};
         dat_s_q <= {dat_s_q[0], ps2_dat_i};
         clk_h_q <= clk_s_q[1];
      end
   end

   assign fall_o = clk_h_q & ~clk_s_q[1];
   assign dat_o  = dat_s_q[1];

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard scancode receiver: frame FSM, idle timeout and
// E0/F0 prefix folding into Extended/Break flags.
module ps2_scancode_rx
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_HZ         = 50_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 5000,
   parameter bit          MAKE_ONLY      = 1'b1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       PS2_CLK,
   input  logic       PS2_DAT,
   output logic [7:0] Ps2DataOut,
   output logic       Done,
   output logic       Extended,
   output logic       Break,
   output logic       FrameErr
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

   if (CLK_HZ < 1000) begin : g_clk_chk
      $error("CLK_HZ too low for PS/2 sampling");
   end

   logic fall;
   logic dat;

   ps2_sync_edge u_sync (
      .clk_i     (CLK),
      .rst_i     (RST),
      .ps2_clk_i (PS2_CLK),
      .ps2_dat_i (PS2_DAT),
      .fall_o    (fall),
      .dat_o     (dat)
   );

   ps2_state_e    state_q;
   logic [2:0]    bit_q;
   logic [7:0]    sh_q;
   logic          par_ok_q;
   logic          fr_vld_q;
   logic          fr_err_q;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          tmo_hit;

   logic [7:0] data_q;
   logic       done_q, ext_q, brk_q, err_q;
   logic       pend_ext_q, pend_brk_q;

   // A falling edge in the same cycle wins over an expiring timer
   assign tmo_hit = (state_q != ST_IDLE) && (tmo_q == TMO_MAX) && !fall;

   always_comb begin
      tmo_d = tmo_q;
      if (fall || tmo_hit)
         tmo_d = '0;
      else if (state_q != ST_IDLE && tmo_q != TMO_MAX)
         tmo_d = tmo_q + 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         bit_q    <= '0;
         sh_q     <= '0;
         par_ok_q <= 1'b0;
         fr_vld_q <= 1'b0;
         fr_err_q <= 1'b0;
         tmo_q    <= '0;
      end else begin
         fr_vld_q <= 1'b0;
         fr_err_q <= 1'b0;
         tmo_q    <= tmo_d;
         if (tmo_hit) begin
            state_q  <= ST_IDLE;
            fr_err_q <= 1'b1;
         end else if (fall) begin
            unique case (state_q)
               ST_IDLE: begin
                  if (!dat) begin
                     state_q <= ST_DATA;
                     bit_q   <= '0;
                  end
               end
               ST_DATA: begin
                  sh_q  <= {dat, sh_q[7:1]};
                  bit_q <= bit_q + 1'b1;
                  if (bit_q == 3'(PS2_NBITS - 1))
                     state_q <= ST_PARITY;
               end
               ST_PARITY: begin
                  par_ok_q <= odd_ok(sh_q, dat);
                  state_q  <= ST_STOP;
               end
               ST_STOP: begin
                  if (par_ok_q && dat)
                     fr_vld_q <= 1'b1;
                  else
                     fr_err_q <= 1'b1;
                  state_q <= ST_IDLE;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         data_q     <= '0;
         done_q     <= 1'b0;
         ext_q      <= 1'b0;
         brk_q      <= 1'b0;
         err_q      <= 1'b0;
         pend_ext_q <= 1'b0;
         pend_brk_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (fr_err_q) begin
            err_q      <= 1'b1;
            pend_ext_q <= 1'b0;
            pend_brk_q <= 1'b0;
         end else if (fr_vld_q) begin
            if (sh_q == PS2_EXT) begin
               pend_ext_q <= 1'b1;
            end else if (sh_q == PS2_BRK) begin
               pend_brk_q <= 1'b1;
            end else begin
               pend_ext_q <= 1'b0;
               pend_brk_q <= 1'b0;
               if (!(pend_brk_q && MAKE_ONLY)) begin
                  data_q <= sh_q;
                  ext_q  <= pend_ext_q;
                  brk_q  <= pend_brk_q;
                  done_q <= 1'b1;
               end
            end
         end
      end
   end

   assign Ps2DataOut = data_q;
   assign Done       = done_q;
   assign Extended   = ext_q;
   assign Break      = brk_q;
   assign FrameErr   = err_q;

endmodule

// File: doc/ps2_scancode_rx.md
PS2_SCANCODE_RX -- requirements
Module: ps2_scancode_rx

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter TIMEOUT_CYCLES, default 5000, idle CLK cycles (100 us at 50 MHz) after which a partial frame is aborted.
REQ-003 Parameter MAKE_ONLY, default 1: 1 = release codes suppressed; 0 = release codes reported with Break=1.
REQ-004 CLK  input  1  system clock; the only clock; all logic on its rising edge.
REQ-005 RST  input  1  reset, synchronous and active-high.
REQ-006 PS2_CLK  input  1  raw keyboard clock line, asynchronous.
REQ-007 PS2_DAT  input  1  raw keyboard data line, asynchronous.
REQ-008 Ps2DataOut  output  8  last reported scancode byte, held until the next report.
REQ-009 Done  output  1  single-cycle strobe: Ps2DataOut/Extended/Break valid.
REQ-010 Extended  output  1  reported code was preceded by 0xE0.
REQ-011 Break  output  1  reported code was preceded by 0xF0 (MAKE_ONLY=0 only).
REQ-012 FrameErr  output  1  single-cycle strobe on parity, start, stop or timeout error.

Function
REQ-013 PS2_CLK and PS2_DAT shall each pass a 2-flop synchronizer, plus one history flop on PS2_CLK for edge detection.
REQ-014 Bit sampling shall occur only on a synchronized PS2_CLK falling edge (prev=1, cur=0).
REQ-015 Frame FSM states: IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: on a falling edge with DAT=0 go to DATA with bit count 0; a falling edge with DAT=1 is ignored.
REQ-017 DATA: shift in 8 bits LSB first (shift-right into bit 7); after the 8th bit go to PARITY.
REQ-018 PARITY: sampled bit plus the 8 data bits shall have odd parity; the result is latched and the FSM goes to STOP.
REQ-019 STOP: sampled bit must be 1; the FSM always returns to IDLE.
REQ-020 A frame is good only if parity is odd and stop=1; otherwise FrameErr pulses one cycle, the byte is discarded, and the prefix flags are cleared.
REQ-021 Timeout counter: cleared on every falling edge, counts while state != IDLE, saturates; reaching TIMEOUT_CYCLES forces IDLE, pulses FrameErr, and clears the prefix flags.
REQ-022 Good byte 0xE0: set the pending-extended flag; no Done.
REQ-023 Good byte 0xF0: set the pending-break flag; no Done.
REQ-024 Good other byte with pending-break=1 and MAKE_ONLY=1: no Done; clear both flags.
REQ-025 Good other byte otherwise: latch Ps2DataOut=byte, Extended=pending-extended, Break=pending-break, pulse Done; clear both flags.
REQ-026 Latency: Done shall assert exactly 2 CLK cycles after the CLK cycle in which the synchronized stop-bit falling edge is seen.
REQ-027 Done and FrameErr shall never be asserted in the same cycle; each is high for exactly one CLK cycle per event.
REQ-028 Back-to-back frames with no idle gap beyond the stop bit shall be received without loss.

Reset
REQ-029 While RST=1, on the next CLK edge: FSM=IDLE, bit count=0, shift register=0, timeout counter=0, prefix flags=0, synchronizers=1.
REQ-030 Reset values of outputs: Ps2DataOut=0x00, Done=0, Extended=0, Break=0, FrameErr=0.
REQ-031 Reset mid-frame shall discard the partial frame with no Done or FrameErr.
REQ-032 The first falling edge after reset release shall be treated as a candidate start bit.

Structure
REQ-033 Package ps2_pkg shall hold the FSM state encoding, the constants PS2_EXT=0xE0 and PS2_BRK=0xF0, and the frame bit count 8.
REQ-034 Sub-module ps2_sync_edge shall provide the synchronizers and falling-edge strobe; the top holds the FSM, timeout and prefix logic.
REQ-035 The Ps2DataOut/Done pair shall connect directly to the game control block's Ps2DataIn/Done inputs.

Verification
REQ-036 Frame 0x1C, correct parity 0 -> one Done, Ps2DataOut=0x1C, Extended=0, Break=0.
REQ-037 Frames F0,1C with MAKE_ONLY=1 -> no Done; then frame 0x23 -> Done with 0x23, Break=0.
REQ-038 Frames E0,75 with MAKE_ONLY=0 -> one Done, 0x75, Extended=1; then F0,75 -> Done, 0x75, Break=1.
REQ-039 Frame 0x1D with parity bit inverted -> FrameErr for one cycle, no Done, Ps2DataOut unchanged.
REQ-040 Start plus 4 bits, then idle longer than 5000 cycles -> FrameErr at timeout; next frame 0x42 -> Done with 0x42.
REQ-041 RST=1 after 5 data bits of a frame -> no strobes, outputs at reset values; next frame 0x3A -> Done with 0x3A.
